// File: rtl/qspi_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : qspi_reg_bridge_if
// Description : Byte stream between the QSPI slave rx/tx blocks and the
//               register bridge, plus the raw slave-select line.
// Revision    : 1.0 - initial release
// ============================================================================
interface qspi_reg_bridge_if;
  logic       ss;       // raw slave select, active low, asynchronous
  logic [7:0] rxdata;   // received byte, valid with rxready
  logic       rxready;  // one-cycle pulse per received byte
  logic       txready;  // one-cycle pulse: next tx byte required
  logic [7:0] txdata;   // byte to transmit

  modport master (
    output ss,
    output rxdata,
    output rxready,
    output txready,
    input  txdata
  );

  modport slave (
    input  ss,
    input  rxdata,
    input  rxready,
    input  txready,
    output txdata
  );
endinterface
`default_nettype wire

// File: rtl/qspi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : qspi_reg_bridge
// Description : Decodes framed QSPI command bytes and runs WRITE/READ bursts
//               against a small register file; supplies the next tx byte.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_reg_bridge #(
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  qspi_reg_bridge_if.slave           bus,
  output logic [3:0]                 led,
  output logic [NUM_REGS*8-1:0]      regs_o,
  output logic                       err,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_NOP   = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_READ  = 2'b10;

  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_armed;
  logic                   w_ss_s;
  logic [3:0]             r_addr, w_addr_n;
  logic                   r_err, w_err_n;
  logic [7:0]             r_txdata, w_tx_n;
  logic [7:0]             r_regs [NUM_REGS];
  logic                   w_we;
  logic [7:0]             w_status;
  logic [3:0]             w_rd_idx;
  logic [7:0]             w_rd_data;
  logic                   w_addr_ok;

  // Next address with wrap at the top of the register file.
  function automatic logic [3:0] addr_inc(input logic [3:0] a);
    return (a == 4'(NUM_REGS - 1)) ? 4'd0 : a + 4'd1;
  endfunction

  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_status  = {STATUS_BYTE[7:4], 1'b0, r_err, 2'b00};
  assign w_addr_ok = ({1'b0, bus.rxdata[3:0]} < 5'(NUM_REGS));
  assign w_rd_idx  = (r_state == S_CMD) ? bus.rxdata[3:0] : r_addr;

  // Synchronise ss; r_vld marks which stages hold genuinely sampled values,
  // so a frame is only armed after ss has really been seen high. This stops
  // ss held low across reset release from looking like a new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ss_sync <= '1;
      r_vld     <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_ss_sync <= {r_ss_sync[SYNC_STAGES-2:0], bus.ss};
      r_vld     <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_armed   <= r_armed | (r_vld[SYNC_STAGES-1] & w_ss_s);
    end
  end

  // Read multiplexer over the register file.
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == 4'(i)) w_rd_data = r_regs[i];
    end
  end

  // State, address, error and tx byte registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_addr   <= 4'd0;
      r_err    <= 1'b0;
      r_txdata <= {STATUS_BYTE[7:4], 4'h0};
    end else begin
      r_state  <= w_state_n;
      r_addr   <= w_addr_n;
      r_err    <= w_err_n;
      r_txdata <= w_tx_n;
    end
  end

  // Next-state decode; frame end (ss_s high) always takes priority.
  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_err_n   = r_err;
    w_tx_n    = w_status;
    w_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_ss_s) w_state_n = S_CMD;
      end
      S_CMD: begin
        if (w_ss_s) begin
          w_state_n = S_IDLE;
        end else if (bus.rxready) begin
          if (bus.rxdata[7:6] == c_OP_NOP) begin
            w_state_n = S_DISCARD;
            w_err_n   = 1'b0;
          end else if (bus.rxdata[7:6] == c_OP_WRITE && w_addr_ok) begin
            w_state_n = S_WRITE;
            w_addr_n  = bus.rxdata[3:0];
          end else if (bus.rxdata[7:6] == c_OP_READ && w_addr_ok) begin
            w_state_n = S_READ;
            w_addr_n  = addr_inc(bus.rxdata[3:0]);
            w_tx_n    = w_rd_data;
          end else begin
            w_state_n = S_DISCARD;
            w_err_n   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (w_ss_s) begin
          w_state_n = S_IDLE;
        end else if (bus.rxready) begin
          w_we     = 1'b1;
          w_addr_n = addr_inc(r_addr);
        end
      end
      S_READ: begin
        w_tx_n = r_txdata;
        if (w_ss_s) begin
          w_state_n = S_IDLE;
          w_tx_n    = w_status;
        end else if (bus.txready) begin
          w_tx_n   = w_rd_data;
          w_addr_n = addr_inc(r_addr);
        end
      end
      S_DISCARD: begin
        if (w_ss_s) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      // One register of the file, written during a WRITE burst.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_regs[i] <= 8'h00;
        else if (w_we && r_addr == 4'(i)) r_regs[i] <= bus.rxdata;
      end
      assign regs_o[8*i +: 8] = r_regs[i];
    end
  endgenerate

  assign led        = r_regs[0][3:0];
  assign err        = r_err;
  assign busy       = ~w_ss_s;
  assign bus.txdata = r_txdata;

endmodule
`default_nettype wire

// File: tb/tb_qspi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_qspi_reg_bridge
// Description : Directed self-checking bench for qspi_reg_bridge with a
//               register model and a queue of expected tx bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_reg_bridge;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  led;
  logic [63:0] regs_o;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_regs [8];
  int         m_addr;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  qspi_reg_bridge_if bus ();

  qspi_reg_bridge #(
    .NUM_REGS    (8),
    .STATUS_BYTE (8'hA5),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .led     (led),
    .regs_o  (regs_o),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_addr = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rxdata  = b;
    bus.rxready = 1'b1;
    @(posedge clk); #1;
    bus.rxready = 1'b0;
  endtask

  task automatic tx_pulse();
    @(posedge clk); #1;
    bus.txready = 1'b1;
    @(posedge clk); #1;
    bus.txready = 1'b0;
  endtask

  // Write command, then data bytes tracked by the model.
  task automatic wr_cmd(input logic [3:0] a);
    send_byte({4'h4, a});
    m_addr = int'(a);
  endtask

  task automatic wr_data(input logic [7:0] b);
    send_byte(b);
    m_regs[m_addr] = b;
    m_addr = (m_addr == 7) ? 0 : m_addr + 1;
  endtask

  task automatic frame_start();
    bus.ss = 1'b0;
    cycles(4);
  endtask

  task automatic frame_end();
    bus.ss = 1'b1;
    cycles(4);
  endtask

  initial begin
    bus.ss      = 1'b1;
    bus.rxdata  = 8'h00;
    bus.rxready = 1'b0;
    bus.txready = 1'b0;
    reset_n     = 1'b0;
    model_clear();
    cycles(3);
    reset_n = 1'b1;
    cycles(4);

    // Reset state, stray byte outside a frame is ignored
    check("rst_regs", regs_o, 64'h0);
    check("rst_txdata", {56'h0, bus.txdata}, 64'hA0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    send_byte(8'h41);
    check("idle_byte_regs", regs_o, 64'h0);
    check("idle_byte_txdata", {56'h0, bus.txdata}, 64'hA0);

    // Write burst to reg0/reg1
    frame_start();
    check("busy_in_frame", {63'h0, busy}, 64'h1);
    wr_cmd(4'h0);
    wr_data(8'h0F);
    wr_data(8'h33);
    check("wr_regs", regs_o, model_flat());
    check("wr_led", {60'h0, led}, {60'h0, m_regs[0][3:0]});
    frame_end();
    check("busy_after_frame", {63'h0, busy}, 64'h0);

    // Read burst from reg0
    frame_start();
    for (int i = 0; i < 4; i++) exp_q.push_back(m_regs[i]);
    send_byte(8'h80);
    exp_b = exp_q.pop_front();
    check("rd_first", {56'h0, bus.txdata}, {56'h0, exp_b});
    for (int k = 0; k < 3; k++) begin
      tx_pulse();
      exp_b = exp_q.pop_front();
      check("rd_next", {56'h0, bus.txdata}, {56'h0, exp_b});
    end
    frame_end();
    check("rd_end_status", {56'h0, bus.txdata}, 64'hA0);

    // Write burst wrapping from reg7 to reg0
    frame_start();
    wr_cmd(4'h7);
    wr_data(8'hAA);
    wr_data(8'hBB);
    check("wrap_regs", regs_o, model_flat());
    check("wrap_led", {60'h0, led}, 64'hB);
    frame_end();

    // Illegal opcode sets err, rest of frame ignored
    frame_start();
    send_byte(8'hC0);
    check("illegal_err", {63'h0, err}, 64'h1);
    send_byte(8'h41);
    send_byte(8'h99);
    check("illegal_ignored", regs_o, model_flat());
    frame_end();
    frame_start();
    check("status_err", {56'h0, bus.txdata}, 64'hA4);
    send_byte(8'h00);
    check("nop_clears_err", {63'h0, err}, 64'h0);
    frame_end();

    // Address beyond the register file
    frame_start();
    send_byte(8'h4A);
    check("badaddr_err", {63'h0, err}, 64'h1);
    send_byte(8'h12);
    check("badaddr_ignored", regs_o, model_flat());
    frame_end();
    frame_start();
    send_byte(8'h00);
    frame_end();

    // Reset in the middle of a write burst
    frame_start();
    wr_cmd(4'h1);
    wr_data(8'h77);
    check("pre_reset_regs", regs_o, model_flat());
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    check("async_reset_regs", regs_o, 64'h0);
    check("async_reset_txdata", {56'h0, bus.txdata}, 64'hA0);
    cycles(2);
    reset_n = 1'b1;
    cycles(5);
    send_byte(8'h41);
    send_byte(8'h55);
    check("post_reset_ignored", regs_o, 64'h0);
    frame_end();
    frame_start();
    wr_cmd(4'h1);
    wr_data(8'h66);
    check("post_reset_new_frame", regs_o, model_flat());
    frame_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
